// File: rtl/ddr3_sched_pkg.sv
// Shared types, timing constants and pin encodings for the DDR3 command scheduler.
package ddr3_sched_pkg;

    // DDR3 timing in controller clock cycles
    localparam int unsigned T_RCD  = 6;
    localparam int unsigned T_RC   = 20;
    localparam int unsigned T_RFC  = 64;
    localparam int unsigned T_REFI = 3120;

    localparam int unsigned N_REQ  = 2;
    localparam int unsigned BA_W   = 3;
    localparam int unsigned ROW_W  = 14;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned PIN_W  = 4;
    localparam int unsigned WAIT_W = 7;
    localparam int unsigned REF_W  = 12;

    // Shared wait counter reloads; a state loaded with V lasts V+1 cycles.
    // RCD: ACT at A, RD/WR at A+T_RCD. RC: next IDLE at A+T_RC, next ACT/REF at A+T_RC+1.
    // RFC: IDLE at R+T_RFC, next ACT at R+T_RFC+1.
    localparam logic [WAIT_W-1:0] RCD_LOAD  = WAIT_W'(T_RCD - 2);
    localparam logic [WAIT_W-1:0] RC_LOAD   = WAIT_W'(T_RC - T_RCD - 2);
    localparam logic [WAIT_W-1:0] RFC_LOAD  = WAIT_W'(T_RFC - 2);
    localparam logic [REF_W-1:0]  REFI_LOAD = REF_W'(T_REFI - 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [PIN_W-1:0] PINS_DESEL = 4'b1111;
    localparam logic [PIN_W-1:0] PINS_NOP   = 4'b0111;
    localparam logic [PIN_W-1:0] PINS_ACT   = 4'b0011;
    localparam logic [PIN_W-1:0] PINS_RD    = 4'b0101;
    localparam logic [PIN_W-1:0] PINS_WR    = 4'b0100;
    localparam logic [PIN_W-1:0] PINS_REF   = 4'b0001;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_REF
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACT,
        ST_WAIT_RCD,
        ST_RW,
        ST_WAIT_RC,
        ST_REF,
        ST_WAIT_RFC
    } state_e;

    // One requester's payload as seen on the request bus
    typedef struct packed {
        logic             we;
        logic [BA_W-1:0]  ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } req_t;

    function automatic logic [PIN_W-1:0] cmd_pins(input cmd_e cmd);
        logic [PIN_W-1:0] pins;
        case (cmd)
            CMD_ACT: pins = PINS_ACT;
            CMD_RD:  pins = PINS_RD;
            CMD_WR:  pins = PINS_WR;
            CMD_REF: pins = PINS_REF;
            default: pins = PINS_NOP;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/ddr3_rr_arb.sv
// Two-requester round-robin arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   valid      : per-requester request (already qualified by the caller)
//   accept     : grant taken this cycle; advances the priority pointer
//   grant_c    : combinational one-hot grant
module ddr3_rr_arb
    import ddr3_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] valid,
    input  logic             accept,
    output logic [N_REQ-1:0] grant_c
);

    // Index of the requester that wins a tie
    logic prio_q;

    always_comb begin
        grant_c = '0;
        if (prio_q == 1'b0) begin
            if (valid[0])      grant_c = 2'b01;
            else if (valid[1]) grant_c = 2'b10;
        end else begin
            if (valid[1])      grant_c = 2'b10;
            else if (valid[0]) grant_c = 2'b01;
        end
    end

    // After granting requester 0 the other one gets priority, and vice versa
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= grant_c[0];
        end
    end

endmodule

// File: rtl/ddr3_cmd_sched.sv
// Closed-page DDR3 command scheduler: round-robin between two requesters,
// ACT -> RD/WR with auto-precharge under tRCD/tRC, periodic all-bank REFRESH.
//   aclk, areset       : clock, synchronous active-high reset
//   init_done          : DDR3 initialisation complete (level)
//   req_valid/ready    : per-requester handshake; ready is combinational, one-hot
//   req_we/ba/row/col  : per-requester access fields, packed by requester index
//   cmd_done/id/we     : pulse with each RD/WR on the pins, its requester and type
//   ddr3_*             : registered command/address pins
module ddr3_cmd_sched
    import ddr3_sched_pkg::*;
(
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     init_done,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*BA_W-1:0]    req_ba,
    input  logic [N_REQ*ROW_W-1:0]   req_row,
    input  logic [N_REQ*COL_W-1:0]   req_col,
    output logic                     cmd_done,
    output logic                     cmd_id,
    output logic                     cmd_we,
    output logic                     ddr3_cke,
    output logic                     ddr3_cs_n,
    output logic                     ddr3_ras_n,
    output logic                     ddr3_cas_n,
    output logic                     ddr3_we_n,
    output logic [BA_W-1:0]          ddr3_ba,
    output logic [ADDR_W-1:0]        ddr3_addr
);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [REF_W-1:0]    ref_cnt_q;
    logic                ref_pend_q;
    logic                lat_we_q;
    logic [BA_W-1:0]     lat_ba_q;
    logic [COL_W-1:0]    lat_col_q;
    logic [PIN_W-1:0]    pins_q;

    logic                run_c;
    logic                ref_due_c;
    logic [N_REQ-1:0]    arb_valid_c;
    logic [N_REQ-1:0]    grant_c;
    logic                grant_id_c;
    req_t                sel_c;
    cmd_e                cmd_d;
    logic [BA_W-1:0]     ba_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                take_req_c;
    logic                ref_take_c;
    logic                rw_cmd_c;

    // Scheduling starts once CKE is up, one cycle after init_done is seen
    assign run_c = init_done & ddr3_cke;

    // An expiring refresh counter blocks the same-cycle grant so REF wins the tie
    assign ref_due_c = ref_pend_q | (init_done & (ref_cnt_q == '0));

    assign arb_valid_c = (state_q == ST_IDLE && run_c && !ref_due_c) ? req_valid : '0;

    ddr3_rr_arb u_arb (
        .clk     (aclk),
        .rst     (areset),
        .valid   (arb_valid_c),
        .accept  (|grant_c),
        .grant_c (grant_c)
    );

    assign req_ready  = grant_c;
    assign grant_id_c = grant_c[1];

    // Fields of the granted requester
    always_comb begin
        sel_c.we  = req_we[grant_id_c];
        sel_c.ba  = grant_id_c ? req_ba[2*BA_W-1:BA_W]    : req_ba[BA_W-1:0];
        sel_c.row = grant_id_c ? req_row[2*ROW_W-1:ROW_W] : req_row[ROW_W-1:0];
        sel_c.col = grant_id_c ? req_col[2*COL_W-1:COL_W] : req_col[COL_W-1:0];
    end

    // Next state; the command chosen here is on the pins during the target state
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cmd_d      = CMD_NOP;
        ba_d       = ddr3_ba;
        addr_d     = ddr3_addr;
        take_req_c = 1'b0;
        ref_take_c = 1'b0;
        if (run_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (ref_due_c) begin
                        state_d    = ST_REF;
                        cmd_d      = CMD_REF;
                        ref_take_c = 1'b1;
                    end else if (|grant_c) begin
                        state_d    = ST_ACT;
                        cmd_d      = CMD_ACT;
                        ba_d       = sel_c.ba;
                        addr_d     = sel_c.row;
                        take_req_c = 1'b1;
                    end
                end
                ST_ACT: begin
                    state_d = ST_WAIT_RCD;
                    wait_d  = RCD_LOAD;
                end
                ST_WAIT_RCD: begin
                    if (wait_q == '0) begin
                        state_d = ST_RW;
                        cmd_d   = lat_we_q ? CMD_WR : CMD_RD;
                        ba_d    = lat_ba_q;
                        // A12 = BL8, A10 = auto-precharge
                        addr_d  = {1'b0, 1'b1, 1'b0, 1'b1, lat_col_q};
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                ST_RW: begin
                    state_d = ST_WAIT_RC;
                    wait_d  = RC_LOAD;
                end
                ST_WAIT_RC: begin
                    if (wait_q == '0) state_d = ST_IDLE;
                    else              wait_d  = wait_q - WAIT_W'(1);
                end
                ST_REF: begin
                    state_d = ST_WAIT_RFC;
                    wait_d  = RFC_LOAD;
                end
                ST_WAIT_RFC: begin
                    if (wait_q == '0) state_d = ST_IDLE;
                    else              wait_d  = wait_q - WAIT_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rw_cmd_c = (cmd_d == CMD_RD) || (cmd_d == CMD_WR);

    // State, counters, request latch and registered pins
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            ref_cnt_q  <= REFI_LOAD;
            ref_pend_q <= 1'b0;
            lat_we_q   <= 1'b0;
            lat_ba_q   <= '0;
            lat_col_q  <= '0;
            ddr3_cke   <= 1'b0;
            pins_q     <= PINS_DESEL;
            ddr3_ba    <= '0;
            ddr3_addr  <= '0;
            cmd_done   <= 1'b0;
            cmd_id     <= 1'b0;
            cmd_we     <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;

            if (init_done) begin
                ref_cnt_q <= (ref_cnt_q == '0) ? REFI_LOAD : ref_cnt_q - REF_W'(1);
            end
            // An expiry while a refresh is already pending does not stack
            if (ref_take_c) begin
                ref_pend_q <= 1'b0;
            end else if (init_done && ref_cnt_q == '0) begin
                ref_pend_q <= 1'b1;
            end

            if (take_req_c) begin
                lat_we_q  <= sel_c.we;
                lat_ba_q  <= sel_c.ba;
                lat_col_q <= sel_c.col;
                cmd_id    <= grant_id_c;
            end

            ddr3_cke  <= ddr3_cke | init_done;
            pins_q    <= run_c ? cmd_pins(cmd_d) : PINS_DESEL;
            ddr3_ba   <= ba_d;
            ddr3_addr <= addr_d;
            cmd_done  <= rw_cmd_c;
            if (rw_cmd_c) cmd_we <= (cmd_d == CMD_WR);
        end
    end

    assign {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n} = pins_q;

endmodule

// File: tb/tb_ddr3_cmd_sched.sv
// Directed bench for ddr3_cmd_sched: reset values, single read timing,
// round-robin writes, refresh priority and ordering, mid-sequence reset, init gating.
module tb_ddr3_cmd_sched;

    logic        aclk = 1'b0;
    logic        areset;
    logic        init_done;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [5:0]  req_ba;
    logic [27:0] req_row;
    logic [19:0] req_col;
    logic        cmd_done;
    logic        cmd_id;
    logic        cmd_we;
    logic        ddr3_cke;
    logic        ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n;
    logic [2:0]  ddr3_ba;
    logic [13:0] ddr3_addr;
    logic [3:0]  pins;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    assign pins = {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n};

    ddr3_cmd_sched dut (
        .aclk       (aclk),
        .areset     (areset),
        .init_done  (init_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_ba     (req_ba),
        .req_row    (req_row),
        .req_col    (req_col),
        .cmd_done   (cmd_done),
        .cmd_id     (cmd_id),
        .cmd_we     (cmd_we),
        .ddr3_cke   (ddr3_cke),
        .ddr3_cs_n  (ddr3_cs_n),
        .ddr3_ras_n (ddr3_ras_n),
        .ddr3_cas_n (ddr3_cas_n),
        .ddr3_we_n  (ddr3_we_n),
        .ddr3_ba    (ddr3_ba),
        .ddr3_addr  (ddr3_addr)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic hold_reset();
        areset    = 1'b1;
        init_done = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_ba    = '0;
        req_row   = '0;
        req_col   = '0;
        repeat (3) tick();
        areset = 1'b0;
    endtask

    // Leaves the bench one cycle after init_done was first sampled ("cycle 0")
    task automatic start();
        hold_reset();
        init_done = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        areset    = 1'b1;
        init_done = 1'b1;
        req_valid = 2'b11;
        repeat (2) tick();
        n_checks++; if (pins !== 4'b1111) begin n_fail++; $display("FAIL reset_pins: got %b expected 1111", pins); end
        n_checks++; if (ddr3_ba !== 3'd0) begin n_fail++; $display("FAIL reset_ba: got %0d expected 0", ddr3_ba); end
        n_checks++; if (ddr3_addr !== 14'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", ddr3_addr); end
        n_checks++; if (ddr3_cke !== 1'b0) begin n_fail++; $display("FAIL reset_cke: got %b expected 0", ddr3_cke); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        n_checks++; if (cmd_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", cmd_done); end
        n_checks++; if (cmd_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %b expected 0", cmd_id); end
        n_checks++; if (cmd_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", cmd_we); end
        req_valid = 2'b00;
        init_done = 1'b0;
        areset    = 1'b0;
    endtask

    task automatic test_single_read();
        hold_reset();
        init_done = 1'b1;
        n_checks++; if (ddr3_cke !== 1'b0) begin n_fail++; $display("FAIL cke_early: got %b expected 0", ddr3_cke); end
        tick();
        n_checks++; if (ddr3_cke !== 1'b1) begin n_fail++; $display("FAIL cke_rise: got %b expected 1", ddr3_cke); end
        req_ba[2:0]   = 3'd2;
        req_row[13:0] = 14'h01A5;
        req_col[9:0]  = 10'h008;
        req_we[0]     = 1'b0;
        req_valid     = 2'b01;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rd_ready: got %b expected 01", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++; if (pins !== 4'b0011) begin n_fail++; $display("FAIL rd_act_pins: got %b expected 0011", pins); end
        n_checks++; if (ddr3_ba !== 3'd2) begin n_fail++; $display("FAIL rd_act_ba: got %0d expected 2", ddr3_ba); end
        n_checks++; if (ddr3_addr !== 14'h01A5) begin n_fail++; $display("FAIL rd_act_addr: got %h expected 01a5", ddr3_addr); end
        for (int i = 1; i < 6; i++) begin
            tick();
            n_checks++;
            if (pins !== 4'b0111 || cmd_done !== 1'b0) begin
                n_fail++; $display("FAIL rd_gap_nop: cycle %0d after ACT got pins %b done %b expected 0111/0", i, pins, cmd_done);
            end
        end
        tick();
        n_checks++; if (pins !== 4'b0101) begin n_fail++; $display("FAIL rd_pins: got %b expected 0101", pins); end
        n_checks++; if (ddr3_addr !== 14'h1408) begin n_fail++; $display("FAIL rd_addr: got %h expected 1408", ddr3_addr); end
        n_checks++; if (ddr3_ba !== 3'd2) begin n_fail++; $display("FAIL rd_ba: got %0d expected 2", ddr3_ba); end
        n_checks++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL rd_done: got %b expected 1", cmd_done); end
        n_checks++; if (cmd_id !== 1'b0) begin n_fail++; $display("FAIL rd_id: got %b expected 0", cmd_id); end
        n_checks++; if (cmd_we !== 1'b0) begin n_fail++; $display("FAIL rd_we: got %b expected 0", cmd_we); end
        tick();
        n_checks++; if (cmd_done !== 1'b0) begin n_fail++; $display("FAIL rd_done_pulse: got %b expected 0", cmd_done); end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_ba [2];
        logic [13:0] exp_row [2];
        logic [9:0]  exp_col [2];
        int last_act;
        exp_ba[0] = 3'd1; exp_row[0] = 14'h0111; exp_col[0] = 10'h011;
        exp_ba[1] = 3'd5; exp_row[1] = 14'h0222; exp_col[1] = 10'h022;
        last_act = 0;
        start();
        req_ba    = {exp_ba[1], exp_ba[0]};
        req_row   = {exp_row[1], exp_row[0]};
        req_col   = {exp_col[1], exp_col[0]};
        req_we    = 2'b11;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            int gid;
            logic [1:0] exp_rdy;
            gid = k % 2;
            exp_rdy = (gid == 0) ? 2'b01 : 2'b10;
            for (int w = 0; w < 40; w++) begin
                if (req_ready !== 2'b00) break;
                tick();
            end
            n_checks++;
            if (req_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, exp_rdy);
            end
            tick();
            n_checks++;
            if (pins !== 4'b0011 || ddr3_ba !== exp_ba[gid] || ddr3_addr !== exp_row[gid]) begin
                n_fail++; $display("FAIL rr_act%0d: got pins %b ba %0d addr %h expected 0011 %0d %h",
                                   k, pins, ddr3_ba, ddr3_addr, exp_ba[gid], exp_row[gid]);
            end
            if (k > 0) begin
                n_checks++;
                if (cyc - last_act != 21) begin
                    n_fail++; $display("FAIL rr_act_spacing%0d: got %0d expected 21", k, cyc - last_act);
                end
            end
            last_act = cyc;
            repeat (6) tick();
            n_checks++;
            if (pins !== 4'b0100 || cmd_id !== gid[0] || cmd_we !== 1'b1 || cmd_done !== 1'b1
                || ddr3_addr !== {4'b0101, exp_col[gid]}) begin
                n_fail++; $display("FAIL rr_wr%0d: got pins %b id %b we %b done %b addr %h expected 0100 %0d 1 1 %h",
                                   k, pins, cmd_id, cmd_we, cmd_done, ddr3_addr, gid, {4'b0101, exp_col[gid]});
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_refresh_priority();
        int early_act;
        early_act = 0;
        start();
        repeat (3118) tick();
        req_ba[2:0]   = 3'd3;
        req_row[13:0] = 14'h02AB;
        req_col[9:0]  = 10'h155;
        req_we[0]     = 1'b0;
        req_valid     = 2'b01;
        #1;
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL refp_ready_blocked: got %b expected 00", req_ready); end
        tick();
        n_checks++; if (pins !== 4'b0001) begin n_fail++; $display("FAIL refp_ref: got %b expected 0001", pins); end
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (pins === 4'b0011) early_act++;
        end
        n_checks++; if (early_act != 0) begin n_fail++; $display("FAIL refp_early_act: got %0d ACTs expected 0", early_act); end
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL refp_ready_after: got %b expected 01", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++;
        if (pins !== 4'b0011 || ddr3_ba !== 3'd3 || ddr3_addr !== 14'h02AB) begin
            n_fail++; $display("FAIL refp_act: got pins %b ba %0d addr %h expected 0011 3 02ab", pins, ddr3_ba, ddr3_addr);
        end
    endtask

    task automatic test_refresh_during_rc();
        int ref_at;
        ref_at = -1;
        start();
        repeat (3107) tick();
        req_ba[5:3]    = 3'd6;
        req_row[27:14] = 14'h03C3;
        req_col[19:10] = 10'h3FF;
        req_we[1]      = 1'b1;
        req_valid      = 2'b10;
        #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL refrc_ready: got %b expected 10", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++; if (pins !== 4'b0011) begin n_fail++; $display("FAIL refrc_act: got %b expected 0011", pins); end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 6) begin
                n_checks++;
                if (pins !== 4'b0100 || cmd_id !== 1'b1) begin
                    n_fail++; $display("FAIL refrc_wr: got pins %b id %b expected 0100 1", pins, cmd_id);
                end
            end
            if (pins === 4'b0001) begin
                ref_at = i;
                break;
            end
        end
        n_checks++;
        if (ref_at != 21) begin
            n_fail++; $display("FAIL refrc_ref_time: got REF %0d cycles after ACT expected 21", ref_at);
        end
    endtask

    task automatic test_reset_mid();
        int bad_pins;
        bad_pins = 0;
        start();
        req_ba[5:3]    = 3'd4;
        req_row[27:14] = 14'h00F0;
        req_col[19:10] = 10'h0AA;
        req_we[1]      = 1'b1;
        req_valid      = 2'b10;
        #1;
        tick();
        n_checks++; if (pins !== 4'b0011) begin n_fail++; $display("FAIL rstm_act: got %b expected 0011", pins); end
        tick();
        areset = 1'b1;
        tick();
        n_checks++; if (pins !== 4'b1111) begin n_fail++; $display("FAIL rstm_pins: got %b expected 1111", pins); end
        n_checks++; if (ddr3_ba !== 3'd0 || ddr3_addr !== 14'd0) begin n_fail++; $display("FAIL rstm_ba_addr: got %0d %h expected 0 0", ddr3_ba, ddr3_addr); end
        n_checks++; if (ddr3_cke !== 1'b0) begin n_fail++; $display("FAIL rstm_cke: got %b expected 0", ddr3_cke); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rstm_ready: got %b expected 00", req_ready); end
        n_checks++; if (cmd_id !== 1'b0 || cmd_done !== 1'b0 || cmd_we !== 1'b0) begin n_fail++; $display("FAIL rstm_cmd: got id %b done %b we %b expected 0 0 0", cmd_id, cmd_done, cmd_we); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pins !== 4'b1111) bad_pins++;
        end
        n_checks++; if (bad_pins != 0) begin n_fail++; $display("FAIL rstm_hold: got %0d non-deselect cycles expected 0", bad_pins); end
        areset = 1'b0;
        tick();
        n_checks++; if (ddr3_cke !== 1'b1) begin n_fail++; $display("FAIL rstm_cke_back: got %b expected 1", ddr3_cke); end
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rstm_ready_back: got %b expected 10", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++;
        if (pins !== 4'b0011 || ddr3_ba !== 3'd4 || ddr3_addr !== 14'h00F0) begin
            n_fail++; $display("FAIL rstm_act_back: got pins %b ba %0d addr %h expected 0011 4 00f0", pins, ddr3_ba, ddr3_addr);
        end
        repeat (6) tick();
        n_checks++;
        if (pins !== 4'b0100 || cmd_done !== 1'b1 || cmd_id !== 1'b1 || cmd_we !== 1'b1 || ddr3_addr !== 14'h14AA) begin
            n_fail++; $display("FAIL rstm_wr_back: got pins %b done %b id %b we %b addr %h expected 0100 1 1 1 14aa",
                               pins, cmd_done, cmd_id, cmd_we, ddr3_addr);
        end
    endtask

    task automatic test_init_low();
        hold_reset();
        req_we    = 2'b11;
        req_valid = 2'b11;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_checks++;
            if (req_ready !== 2'b00 || pins !== 4'b1111 || ddr3_cke !== 1'b0) begin
                n_fail++; $display("FAIL init_low%0d: got ready %b pins %b cke %b expected 00 1111 0", i, req_ready, pins, ddr3_cke);
            end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset    = 1'b1;
        init_done = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_ba    = '0;
        req_row   = '0;
        req_col   = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_refresh_priority();
        test_refresh_during_rc();
        test_reset_mid();
        test_init_low();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
